pht_ctrl: RTL and testbench

PHT_CTRL -- requirements
Module: pht_ctrl

---
 rtl/pht_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pht_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pht_ctrl.sv
// Pattern history table controller: initialises a table of 2-bit saturating
// counters held in a dual-port SRAM, serves predictions on port 0 and
// read-modify-write updates on port 1.
module pht_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pred_valid,
  input  logic [ADDR_WIDTH-1:0] pred_idx,
  output logic                  pred_ready,
  output logic                  pred_resp_valid,
  output logic                  pred_taken,
  output logic [DATA_WIDTH-1:0] pred_ctr,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_idx,
  input  logic                  upd_taken,
  output logic                  upd_ready,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  csb1,
  output logic                  web1,
  output logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] dout1
);

  localparam logic [1:0] INIT   = 2'd0;
  localparam logic [1:0] IDLE   = 2'd1;
  localparam logic [1:0] UPD_WR = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [ADDR_WIDTH-1:0] upd_idx_q, upd_idx_d;
  logic                  upd_taken_q, upd_taken_d;
  logic                  resp_pend_q, resp_pend_d;
  logic                  byp_q, byp_d;
  logic [DATA_WIDTH-1:0] byp_val_q, byp_val_d;

  logic                  table_ready;
  logic                  pred_acc;
  logic [DATA_WIDTH-1:0] new_ctr;

  assign table_ready = (state_q != INIT);
  assign pred_acc    = pred_valid & table_ready;

  // Saturating counter step applied to the value read back on port 1.
  always_comb begin
    new_ctr = dout1;
    if (upd_taken_q) begin
      if (dout1 != '1) new_ctr = dout1 + DATA_WIDTH'(1);
    end else begin
      if (dout1 != '0) new_ctr = dout1 - DATA_WIDTH'(1);
    end
  end

  // Next-state: FSM, init sweep, update latch and prediction response tracking.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    upd_idx_d   = upd_idx_q;
    upd_taken_d = upd_taken_q;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (upd_valid) begin
          upd_idx_d   = upd_idx;
          upd_taken_d = upd_taken;
          state_d     = UPD_WR;
        end
      end
      UPD_WR:  state_d = IDLE;
      default: state_d = INIT;
    endcase
    resp_pend_d = pred_acc;
    // The port-0 read issued alongside the write would return the stale value.
    byp_d       = pred_acc && (state_q == UPD_WR) && (pred_idx == upd_idx_q);
    byp_val_d   = new_ctr;
  end

  // Outputs: everything forced inactive while reset is held.
  always_comb begin
    csb0            = 1'b1;
    web0            = 1'b1;
    addr0           = '0;
    din0            = '0;
    csb1            = 1'b1;
    web1            = 1'b1;
    addr1           = '0;
    din1            = '0;
    pred_ready      = 1'b0;
    upd_ready       = 1'b0;
    pred_resp_valid = 1'b0;
    pred_ctr        = '0;
    init_done       = 1'b0;
    if (!rst) begin
      init_done  = table_ready;
      pred_ready = table_ready;
      upd_ready  = (state_q == IDLE);
      if (pred_acc) begin
        csb0  = 1'b0;
        addr0 = pred_idx;
      end
      case (state_q)
        INIT: begin
          csb1  = 1'b0;
          web1  = 1'b0;
          addr1 = init_cnt_q;
          din1  = INIT_VAL;
        end
        IDLE: begin
          if (upd_valid) begin
            csb1  = 1'b0;
            addr1 = upd_idx;
          end
        end
        UPD_WR: begin
          csb1  = 1'b0;
          web1  = 1'b0;
          addr1 = upd_idx_q;
          din1  = new_ctr;
        end
        default: ;
      endcase
      pred_resp_valid = resp_pend_q;
      if (resp_pend_q) pred_ctr = byp_q ? byp_val_q : dout0;
    end
    pred_taken = pred_ctr[DATA_WIDTH-1];
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      upd_idx_q   <= '0;
      upd_taken_q <= 1'b0;
      resp_pend_q <= 1'b0;
      byp_q       <= 1'b0;
      byp_val_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      upd_idx_q   <= upd_idx_d;
      upd_taken_q <= upd_taken_d;
      resp_pend_q <= resp_pend_d;
      byp_q       <= byp_d;
      byp_val_q   <= byp_val_d;
    end
  end

endmodule

// File: tb/tb_pht_ctrl.sv
// Directed bench for pht_ctrl with a behavioural dual-port SRAM model.
module tb_pht_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pred_valid, pred_ready, pred_resp_valid, pred_taken;
  logic [3:0] pred_idx;
  logic [1:0] pred_ctr;
  logic       upd_valid, upd_taken, upd_ready, init_done;
  logic [3:0] upd_idx;
  logic       csb0, web0, csb1, web1;
  logic [3:0] addr0, addr1;
  logic [1:0] din0, din1, dout0, dout1;

  int n_chk = 0;
  int n_fail = 0;

  pht_ctrl dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_idx(pred_idx), .pred_ready(pred_ready),
    .pred_resp_valid(pred_resp_valid), .pred_taken(pred_taken), .pred_ctr(pred_ctr),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .init_done(init_done),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0),
    .csb1(csb1), .web1(web1), .addr1(addr1), .din1(din1), .dout1(dout1)
  );

  always #5 clk = ~clk;

  // SRAM model: a write captured on one edge commits on the next edge, before
  // any read captured on that edge looks at the array.
  logic [1:0] mem [16];
  logic       wr_pend = 1'b0;
  logic [3:0] wr_addr;
  logic [1:0] wr_data;
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 2'b11;
    dout0 = '0;
    dout1 = '0;
  end
  always @(posedge clk) begin
    if (wr_pend) mem[wr_addr] = wr_data;
    wr_pend = !csb1 && !web1;
    wr_addr = addr1;
    wr_data = din1;
    if (!csb1 && web1) dout1 <= mem[addr1];
    if (!csb0) dout0 <= mem[addr0];
  end

  logic [22:0] outs;
  assign outs = {csb0, web0, csb1, web1, addr0, addr1, din0, din1, pred_ready, upd_ready,
                 pred_resp_valid, pred_taken, pred_ctr, init_done};
  localparam logic [22:0] OutsReset = 23'h780000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full update: read cycle then write cycle, checking the written value.
  task automatic do_upd(input logic [3:0] idx, input logic tk, input logic [1:0] exp_new);
    upd_valid = 1'b1; upd_idx = idx; upd_taken = tk;
    #1;
    chk("upd_ready", 32'(upd_ready), 1);
    chk("upd_rd", 32'({csb1, web1, addr1}), 32'({1'b0, 1'b1, idx}));
    tick();
    upd_valid = 1'b0;
    #1;
    chk("upd_wr", 32'({csb1, web1, addr1, din1}), 32'({1'b0, 1'b0, idx, exp_new}));
    tick();
  endtask

  task automatic do_pred(input logic [3:0] idx, input logic [1:0] exp_ctr);
    pred_valid = 1'b1; pred_idx = idx;
    #1;
    chk("pred_rd", 32'({pred_ready, csb0, web0, addr0}), 32'({1'b1, 1'b0, 1'b1, idx}));
    tick();
    pred_valid = 1'b0;
    #1;
    chk("pred_resp", 32'({pred_resp_valid, pred_ctr, pred_taken}),
        32'({1'b1, exp_ctr, exp_ctr[1]}));
    tick();
    chk("pred_resp_drop", 32'(pred_resp_valid), 0);
  endtask

  task automatic init_sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk(tag, 32'({csb1, web1, addr1, din1, init_done}), 32'({2'b00, 4'(i), 2'b01, 1'b0}));
      tick();
    end
    chk("init_done", 32'({init_done, upd_ready, csb1}), 32'b111);
  endtask

  logic [1:0] exp_r [6] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
  int acc_cnt, resp_cnt;

  initial begin
    rst = 1'b1; pred_valid = 0; pred_idx = 0; upd_valid = 0; upd_idx = 0; upd_taken = 0;
    @(negedge clk); @(negedge clk);
    chk("reset_outs", 32'(outs), 32'(OutsReset));

    // Initialisation sweep and a first prediction.
    rst = 1'b0;
    #1;
    init_sweep("init");
    do_pred(4'd5, 2'd1);

    // Saturation up, prediction, then back down; updates are back to back.
    do_upd(4'd3, 1'b1, 2'd2);
    do_upd(4'd3, 1'b1, 2'd3);
    do_upd(4'd3, 1'b1, 2'd3);
    do_upd(4'd3, 1'b1, 2'd3);
    do_pred(4'd3, 2'd3);
    do_upd(4'd3, 1'b0, 2'd2);
    do_upd(4'd3, 1'b0, 2'd1);
    do_upd(4'd3, 1'b0, 2'd0);
    do_upd(4'd3, 1'b0, 2'd0);

    // Predict colliding with the write of the same index.
    upd_valid = 1'b1; upd_idx = 4'd7; upd_taken = 1'b1;
    tick();
    upd_valid = 1'b0; pred_valid = 1'b1; pred_idx = 4'd7;
    #1;
    chk("byp_wr", 32'({csb1, web1, addr1, din1, pred_ready}), 32'({2'b00, 4'd7, 2'd2, 1'b1}));
    tick();
    pred_valid = 1'b0;
    #1;
    chk("byp_resp", 32'({pred_resp_valid, pred_ctr, pred_taken}), 32'({1'b1, 2'd2, 1'b1}));
    tick();

    // Held update request plus a predict every cycle to the same index.
    acc_cnt = 0; resp_cnt = 0;
    upd_valid = 1'b1; upd_idx = 4'd9; upd_taken = 1'b1;
    pred_valid = 1'b1; pred_idx = 4'd9;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("tput_ready", 32'(upd_ready), 32'(i % 2 == 0));
      if (upd_ready) acc_cnt++;
      if (i > 0) begin
        chk("tput_resp", 32'({pred_resp_valid, pred_ctr}), 32'({1'b1, exp_r[i-1]}));
        if (pred_resp_valid) resp_cnt++;
      end
      tick();
    end
    upd_valid = 1'b0; pred_valid = 1'b0;
    #1;
    chk("tput_resp", 32'({pred_resp_valid, pred_ctr}), 32'({1'b1, exp_r[5]}));
    if (pred_resp_valid) resp_cnt++;
    chk("tput_acc", 32'(acc_cnt), 3);
    chk("tput_nresp", 32'(resp_cnt), 6);
    tick();

    // Reset in the middle of initialisation.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 9; i++) tick();
    chk("init_mid", 32'({csb1, addr1}), 32'({1'b0, 4'd9}));
    rst = 1'b1;
    #1;
    chk("rst_mid_init", 32'(outs), 32'(OutsReset));
    tick();
    rst = 1'b0;
    #1;
    init_sweep("reinit");

    // Reset while an update write and a prediction are in flight.
    upd_valid = 1'b1; upd_idx = 4'd3; upd_taken = 1'b1;
    tick();
    upd_valid = 1'b0; pred_valid = 1'b1; pred_idx = 4'd3;
    #1;
    chk("pre_rst_wr", 32'({csb1, web1, din1}), 32'({2'b00, 2'd2}));
    rst = 1'b1;
    #1;
    chk("rst_upd_wr", 32'(outs), 32'(OutsReset));
    tick();
    pred_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("no_resp_after_rst", 32'({pred_resp_valid, csb1, addr1}), 32'({1'b0, 1'b0, 4'd0}));
    tick();
    tick();
    chk("no_write_after_rst", 32'(mem[3]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
